pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions: load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses through a ready handshake. It sits beside the datapath and owns no data, only control.

---
 rtl/mips_pipe_pkg.sv | 17 +
 rtl/load_use_detect.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   state_t        : hazard sequencer states (RUN, MEM_WAIT, ERR)
//   DEF_REG_ADDR_W : default register-index width
//   REG_ZERO       : index of the hard-wired $zero register
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [DEF_REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator. Pure combinational; also used by the
// forwarding unit.
//   idex_memread : instruction in EX is a load
//   idex_rt      : load destination register in EX
//   id_rs, id_rt : source registers of the instruction in ID
//   hazard       : ID consumes the value the EX load has not yet produced
module load_use_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  hazard
);

    // A load into $zero writes nothing, so it can never create a hazard.
    assign hazard = idex_memread
                  & (idex_rt != REG_ADDR_W'(REG_ZERO))
                  & ((idex_rt == id_rs) | (idex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Handshake: the data memory is requested while mem_req=1; the access
// completes in the cycle where mem_req=1 and mem_ready=1. mem_ready in any
// other cycle is ignored.
// Ports:
//   clk, reset (async, active-low)
//   id_rs, id_rt, idex_memread, idex_rt : load-use hazard inputs
//   ex_branch_taken, id_jump            : control-flow redirects
//   exmem_memread, exmem_memwrite       : MEM stage accesses data memory
//   mem_ready / mem_req                 : data-memory handshake
//   pc_en, ifid_en, idex_en, exmem_en   : stage load enables
//   ifid_flush, idex_flush              : synchronous stage clear (bubble)
//   memwb_bubble                        : MEM/WB loads zeros instead of results
//   mem_timeout_err                     : sticky, cleared only by reset
//   stall_count                         : saturating count of pc_en=0 cycles
//   state_dbg                           : current sequencer state
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   idex_memread,
    input  logic [REG_ADDR_W-1:0]  idex_rt,
    input  logic                   ex_branch_taken,
    input  logic                   id_jump,
    input  logic                   exmem_memread,
    input  logic                   exmem_memwrite,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_bubble,
    output logic                   mem_timeout_err,
    output logic [STALL_CNT_W-1:0] stall_count,
    output state_t                 state_dbg
);

    state_t                 state_q, state_d;
    logic [7:0]             timer_q, timer_d;
    logic                   err_q, err_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_use;
    logic mem_access;
    logic freeze;
    logic resolve;
    logic [7:0] timer_inc;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .hazard       (load_use)
    );

    assign mem_access = exmem_memread | exmem_memwrite;
    assign timer_inc  = timer_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        freeze        = 1'b0;
        resolve       = 1'b0;
        mem_req       = 1'b0;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_bubble  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_access) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        resolve = 1'b1;
                    end else begin
                        freeze  = 1'b1;
                        state_d = MEM_WAIT;
                        timer_d = '0;
                    end
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // Release cycle: MEM/WB captures ReadData and the held
                    // hazards/redirects are resolved against the advancing pipe.
                    resolve = 1'b1;
                    state_d = RUN;
                end else begin
                    freeze  = 1'b1;
                    timer_d = timer_inc;
                    if (timer_inc == 8'(MEM_TIMEOUT)) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end

        // Branch squashes the younger instructions, so the load-use stall is
        // moot; load-use holds ID, so a jump there is simply re-decoded.
        if (resolve) begin
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end

        err_d         = err_q | (state_d == ERR);
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            timer_q       <= '0;
            err_q         <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            err_q         <= err_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_count     = stall_count_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;
    import mips_pipe_pkg::*;

    localparam int W = 9;

    // Expected output words: {err, mem_req, pc_en, ifid_en, idex_en,
    //                         exmem_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [W-1:0] IDLE = 9'b0_0_1111_000;
    localparam logic [W-1:0] LU   = 9'b0_0_0011_010;
    localparam logic [W-1:0] BR   = 9'b0_0_1111_110;
    localparam logic [W-1:0] JMP  = 9'b0_0_1111_100;
    localparam logic [W-1:0] MRDY = 9'b0_1_1111_000;
    localparam logic [W-1:0] MBR  = 9'b0_1_1111_110;
    localparam logic [W-1:0] MLU  = 9'b0_1_0011_010;
    localparam logic [W-1:0] FRZ  = 9'b0_1_0000_001;
    localparam logic [W-1:0] ERRV = 9'b1_0_0000_001;

    typedef struct {
        logic       lu;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       jmp;
        logic       mrd;
        logic       mwr;
        logic       rdy;
        logic [W-1:0] exp;
        string      name;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]  id_rs, id_rt, idex_rt;
    logic        idex_memread, ex_branch_taken, id_jump;
    logic        exmem_memread, exmem_memwrite, mem_ready;
    logic        mem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_bubble, mem_timeout_err;
    logic [15:0] stall_count;
    state_t      state_dbg;
    logic [W-1:0] outs;

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (4),
        .REG_ADDR_W  (5),
        .STALL_CNT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .exmem_memread   (exmem_memread),
        .exmem_memwrite  (exmem_memwrite),
        .mem_ready       (mem_ready),
        .mem_req         (mem_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
        .mem_timeout_err (mem_timeout_err),
        .stall_count     (stall_count),
        .state_dbg       (state_dbg)
    );

    assign outs = {mem_timeout_err, mem_req, pc_en, ifid_en, idex_en,
                   exmem_en, ifid_flush, idex_flush, memwb_bubble};

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_stalls;
    int           checks = 0;
    int           errors = 0;

    function automatic vec_t mk(input string n, input logic lu,
                                input logic [4:0] ex_rt, input logic [4:0] rs,
                                input logic [4:0] rt, input logic br,
                                input logic jmp, input logic mrd,
                                input logic mwr, input logic rdy,
                                input logic [W-1:0] e);
        vec_t v;
        v.name = n; v.lu = lu; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt;
        v.br = br; v.jmp = jmp; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
        v.exp = e;
        return v;
    endfunction

    task automatic drive_zero();
        idex_memread = 1'b0; idex_rt = '0; id_rs = '0; id_rt = '0;
        ex_branch_taken = 1'b0; id_jump = 1'b0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0; mem_ready = 1'b0;
    endtask

    // driver: one cycle per vector, sampled on the falling edge
    task automatic step(input vec_t v);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        idex_memread = v.lu; idex_rt = v.ex_rt; id_rs = v.rs; id_rt = v.rt;
        ex_branch_taken = v.br; id_jump = v.jmp;
        exmem_memread = v.mrd; exmem_memwrite = v.mwr; mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (outs !== e) begin
            errors++;
            $display("FAIL %s outs=%b expected=%b", v.name, outs, e);
        end
        checks++;
        if (stall_count !== exp_stalls) begin
            errors++;
            $display("FAIL %s_stall_count got=%0d expected=%0d", v.name, stall_count, exp_stalls);
        end
        if (e[6] == 1'b0) exp_stalls++;
    endtask

    task automatic chk_state(input string n, input state_t s);
        checks++;
        if (state_dbg !== s) begin
            errors++;
            $display("FAIL %s state got=%0d expected=%0d", n, state_dbg, s);
        end
    endtask

    task automatic chk_reset_vals(input string n);
        chk_state(n, RUN);
        checks++;
        if (outs !== IDLE || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL %s outs=%b stall=%0d expected=%b stall=0", n, outs, stall_count, IDLE);
        end
    endtask

    vec_t vecs[14];

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] r;
        vecs[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        vecs[1]  = mk("lu_rs",         1, 8, 8, 0, 0, 0, 0, 0, 0, LU);
        vecs[2]  = mk("lu_rt",         1, 9, 3, 9, 0, 0, 0, 0, 0, LU);
        vecs[3]  = mk("load_zero",     1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        vecs[4]  = mk("load_nomatch",  1, 8, 3, 4, 0, 0, 0, 0, 0, IDLE);
        vecs[5]  = mk("match_noload",  0, 8, 8, 8, 0, 0, 0, 0, 0, IDLE);
        vecs[6]  = mk("branch",        0, 0, 0, 0, 1, 0, 0, 0, 0, BR);
        vecs[7]  = mk("branch_lu",     1, 8, 8, 0, 1, 0, 0, 0, 0, BR);
        vecs[8]  = mk("jump",          0, 0, 0, 0, 0, 1, 0, 0, 0, JMP);
        vecs[9]  = mk("jump_lu",       1, 7, 0, 7, 0, 1, 0, 0, 0, LU);
        vecs[10] = mk("mrd_zero_wait", 0, 0, 0, 0, 0, 0, 1, 0, 1, MRDY);
        vecs[11] = mk("mwr_rdy_br",    0, 0, 0, 0, 1, 0, 0, 1, 1, MBR);
        vecs[12] = mk("rdy_ignored",   0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);
        vecs[13] = mk("mwr_rdy_lu",    1, 5, 5, 0, 0, 0, 0, 1, 1, MLU);

        drive_zero();
        reset = 1'b0;
        exp_stalls = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("reset_state");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) step(vecs[i]);

        // random register indices: match stalls, neighbouring index does not
        for (int i = 0; i < 4; i++) begin
            r = 5'($urandom_range(1, 31));
            step(mk("rand_lu", 1, r, r, 5'($urandom_range(0, 31)), 0, 0, 0, 0, 0, LU));
            step(mk("rand_nolu", 1, r, r ^ 5'd1, r ^ 5'd2, 0, 0, 0, 0, 0, IDLE));
        end

        // single load-use bubble then re-issue
        step(mk("lu_once", 1, 8, 8, 0, 0, 0, 0, 0, 0, LU));
        step(mk("lu_after", 0, 8, 8, 0, 0, 0, 0, 0, 0, IDLE));

        // memory wait: ready on the 4th cycle
        step(mk("mw_frz1", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
        chk_state("mw_state_run", RUN);
        step(mk("mw_frz2", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
        chk_state("mw_state_wait", MEM_WAIT);
        step(mk("mw_frz3", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
        step(mk("mw_release", 0, 0, 0, 0, 0, 0, 1, 0, 1, MRDY));
        step(mk("mw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        chk_state("mw_state_back", RUN);

        // ready arrives in the last cycle before timeout
        for (int i = 0; i < 4; i++)
            step(mk("late_frz", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
        step(mk("late_release", 0, 0, 0, 0, 0, 0, 1, 0, 1, MRDY));
        step(mk("late_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));

        // branch + load-use held behind a memory stall
        step(mk("pend_frz", 1, 8, 8, 0, 1, 1, 1, 0, 0, FRZ));
        step(mk("pend_frz2", 1, 8, 8, 0, 1, 1, 1, 0, 0, FRZ));
        step(mk("pend_release", 1, 8, 8, 0, 1, 0, 1, 0, 1, MBR));
        step(mk("pend_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));

        // jump hidden by load-use, then re-decoded
        step(mk("jmp_lu", 1, 8, 8, 0, 0, 1, 0, 0, 0, LU));
        step(mk("jmp_alone", 0, 0, 0, 0, 0, 1, 0, 0, 0, JMP));

        // timeout: ERR after the 5th edge, sticky, mem_ready ignored
        for (int i = 0; i < 5; i++)
            step(mk("to_frz", 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        step(mk("to_err", 0, 0, 0, 0, 0, 0, 0, 1, 0, ERRV));
        chk_state("to_state_err", ERR);
        step(mk("to_err_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1, ERRV));
        step(mk("to_err_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, ERRV));

        // asynchronous reset pulse out of ERR
        @(posedge clk);
        #1;
        drive_zero();
        #1;
        reset = 1'b0;
        #1;
        chk_reset_vals("err_reset");
        exp_stalls = '0;
        @(negedge clk);
        reset = 1'b1;
        step(mk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        step(mk("post_reset_lu", 1, 3, 0, 3, 0, 0, 0, 0, 0, LU));
        step(mk("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
